i2c_bus_arb: RTL and testbench
==============================

# i2c_bus_arb

Dynamic arbiter that shares the single physical I2C pad pair between the native I2C controller (requester 0) and the APB I2C controller (requester 1). It replaces the static I2C select register in the SoC top. Ownership changes only when the I2C bus is observed idle, so a transaction is never cut mid-frame. The block sits between the two controllers' `i2c_if` signals and the `i2c` pad interface.

## Interface

Parameters:
- `IDLE_CYC`, default 64: consecutive cycles with SCL=SDA=1 that declare the bus free.
- `WDOG_CYC`, default 65536: maximum ownership cycles; used only with `I2C_ARB_WDOG_EN`.

Ports (direction, width, meaning):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in 2: per-requester bus request; level, held for the whole transaction.
- `gnt_o` out 2: one-hot or zero grant; registered.
- `m_scl_o_i`, `m_sda_o_i` in 2: requester output values.
- `m_scl_oe_i`, `m_sda_oe_i` in 2: requester output enables; 1 = drive. Callers normalise polarity before this block.
- `m_scl_i_o`, `m_sda_i_o` out 2: line value returned to each requester.
- `pad_scl_i`, `pad_sda_i` in 1: raw pad inputs.
- `pad_scl_o`, `pad_sda_o`, `pad_scl_oe_o`, `pad_sda_oe_o` out 1: pad drive.
- `bus_busy_o` out 1: registered bus-busy flag.
- `wdog_o` out 1: one-cycle pulse on a watchdog revoke.

## Operation

Input path:
- Pad inputs pass through a 2-flop synchroniser, then a 1-flop history stage.
- START = SDA 1→0 while SCL=1. STOP = SDA 0→1 while SCL=1. Both are evaluated on synchronised values.

Busy tracking:
- `bus_busy_o` is set on START.
- It is cleared on STOP, or when the idle counter reaches `IDLE_CYC`.
- The idle counter increments while synchronised SCL=SDA=1, clears otherwise, and saturates at `IDLE_CYC`.
- If START and an idle-counter hit occur in the same cycle, START wins.

FSM states: IDLE, OWN0, OWN1, DRAIN.
- **IDLE → OWN*k***: when any `req_i` is set and `bus_busy_o`=0.
  - If both requesters ask, grant the one that is not `last`, where `last` is the most recent owner. `last` resets to 1, so requester 0 wins the first tie.
  - On grant, update `last`.
- **OWN*k* → DRAIN**: when `req_i[k]` falls, or on a watchdog expiry.
- **DRAIN → IDLE**: when `bus_busy_o`=0.

Output muxing:
- In OWN*k*, the pad outputs are a combinational mux of requester *k* selected by the registered state. `m_*_i_o[k]` carries the synchronised line values.
- A non-owner, and every requester in IDLE or DRAIN, sees `m_*_i_o`=1.
- In IDLE and DRAIN the pads are released: `*_oe_o`=0, `*_o`=1.

Other rules:
- A request that rises in the same cycle as a detected START is not granted; busy dominates.
- If both `req_i` bits drop while in DRAIN, the block still waits for the bus to go idle.

## Timing

- Reset values: state=IDLE, `gnt_o`=0, `bus_busy_o`=0, `wdog_o`=0, idle counter=0, `last`=1.
  - Pads are released (oe=0, o=1), and `m_*_i_o`=1 for both requesters.
- Reset asserted mid-transaction releases the pads on the first clock edge with `rst_i`=1.
- Grant latency: `gnt_o` rises 1 cycle after the sampling edge where `req_i` is set with the bus idle.
- Release latency: pads are released 1 cycle after `req_i[k]` falls.
- Line-event latency: a pad transition reaches the START/STOP detectors 3 cycles later.
- After SCL=SDA=1 settles, busy clears after ≈`IDLE_CYC`+3 cycles.
- Requesters must not drive before `gnt_o[k]`=1. Any drive while ungranted is ignored.

## Configuration

`I2C_ARB_WDOG_EN` defined:
- An ownership counter clears on entry to OWN*k* and increments each cycle in OWN*k*.
- At `WDOG_CYC` the FSM goes to DRAIN, `gnt_o` drops, and `wdog_o` pulses for 1 cycle.
- The revoked requester is not re-granted until its `req_i` has been seen low for at least 1 cycle.

`I2C_ARB_WDOG_EN` undefined:
- No counter is built, `wdog_o` is tied to 0, and ownership is unbounded.

## Test plan

- **Reset, then single request:** `req_i`=01 with the bus idle → `gnt_o`=01 one cycle later; pads follow requester 0; `m_*_i_o[1]`=1.
- **Simultaneous requests:** `req_i`=11 from reset → grant 01. Requester 0 drops, STOP is generated, idle is reached → grant 10. Repeat the tie → 01.
- **Busy hold-off:** an external START (SDA low with SCL high), then `req_i`=10 → no grant until STOP is detected; grant then follows within 1 cycle.
- **Drain:** owner drives SDA low, then drops `req_i` → pads released next cycle. State stays DRAIN until `IDLE_CYC` idle cycles elapse, then IDLE.
- **Reset mid-frame:** assert `rst_i` while OWN1 with `sda_oe`=1 → next cycle `gnt_o`=0 and `pad_sda_oe_o`=0.
- **Watchdog (`I2C_ARB_WDOG_EN`, `WDOG_CYC`=16):** hold `req_i`=01 → `wdog_o` pulses exactly once at cycle 16 of ownership and `gnt_o`=00. No re-grant while `req_i[0]` stays high.

Source files
------------

// File: rtl/i2c_bus_arb.sv
// Idle-gated arbiter sharing one I2C pad pair between two controllers.
// Optional ownership watchdog is built only when I2C_ARB_WDOG_EN is defined.
module i2c_bus_arb #(
    parameter int unsigned IDLE_CYC = 64,
    parameter int unsigned WDOG_CYC = 65536
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    input  logic [1:0] m_scl_o_i,
    input  logic [1:0] m_sda_o_i,
    input  logic [1:0] m_scl_oe_i,
    input  logic [1:0] m_sda_oe_i,
    output logic [1:0] m_scl_i_o,
    output logic [1:0] m_sda_i_o,
    input  logic       pad_scl_i,
    input  logic       pad_sda_i,
    output logic       pad_scl_o,
    output logic       pad_sda_o,
    output logic       pad_scl_oe_o,
    output logic       pad_sda_oe_o,
    output logic       bus_busy_o,
    output logic       wdog_o
);

    localparam int unsigned IdleW = $clog2(IDLE_CYC + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_CYC);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StOwn0  = 2'd1;
    localparam logic [1:0] StOwn1  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [1:0]       scl_sync_q, sda_sync_q;
    logic             scl_hist_q, sda_hist_q;
    logic             scl_s, sda_s;
    logic             start_det, stop_det;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             idle_hit;
    logic             busy_q, busy_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [1:0]       elig;
    logic             pick;
    logic             owning;
    logic             wdog_exp;

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    // SCL must be high in both samples so a simultaneous release of both lines is not a STOP
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], pad_scl_i};
            sda_sync_q <= {sda_sync_q[0], pad_sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign idle_hit = (idle_cnt_q == IdleMax);

    always_comb begin
        idle_cnt_d = '0;
        if (scl_s && sda_s) begin
            idle_cnt_d = idle_hit ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (start_det) begin
            busy_d = 1'b1;
        end else if (stop_det || idle_hit) begin
            busy_d = 1'b0;
        end
    end

    assign owning = (state_q == StOwn0) || (state_q == StOwn1);
    assign pick   = (elig == 2'b11) ? ~last_q : elig[1];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                // A START seen this cycle blocks the grant even though busy_q is still low
                if ((elig != 2'b00) && !busy_q && !start_det) begin
                    state_d = pick ? StOwn1 : StOwn0;
                    last_d  = pick;
                end
            end
            StOwn0:  if (!req_i[0] || wdog_exp) state_d = StDrain;
            StOwn1:  if (!req_i[1] || wdog_exp) state_d = StDrain;
            StDrain: if (!busy_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign gnt_d = {state_d == StOwn1, state_d == StOwn0};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
            gnt_q      <= 2'b00;
            last_q     <= 1'b1;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            busy_q     <= busy_d;
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign bus_busy_o = busy_q;

`ifdef I2C_ARB_WDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYC + 1);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYC - 1);

    logic [WdogW-1:0] own_cnt_q, own_cnt_d;
    logic [1:0]       blk_q, blk_d;
    logic             wdog_q;

    assign wdog_exp  = owning && (own_cnt_q == WdogLast);
    assign own_cnt_d = owning ? own_cnt_q + 1'b1 : '0;
    // A revoked requester stays blocked until it has dropped its request
    assign blk_d     = (blk_q & req_i) |
                       (wdog_exp ? {state_q == StOwn1, state_q == StOwn0} : 2'b00);
    assign elig      = req_i & ~blk_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            own_cnt_q <= '0;
            blk_q     <= 2'b00;
            wdog_q    <= 1'b0;
        end else begin
            own_cnt_q <= own_cnt_d;
            blk_q     <= blk_d;
            wdog_q    <= wdog_exp;
        end
    end

    assign wdog_o = wdog_q;
`else
    logic unused_wdog_cyc;
    assign unused_wdog_cyc = ^WDOG_CYC;
    assign wdog_exp        = 1'b0;
    assign elig            = req_i;
    assign wdog_o          = 1'b0;
`endif

    always_comb begin
        pad_scl_o    = 1'b1;
        pad_sda_o    = 1'b1;
        pad_scl_oe_o = 1'b0;
        pad_sda_oe_o = 1'b0;
        m_scl_i_o    = 2'b11;
        m_sda_i_o    = 2'b11;
        case (state_q)
            StOwn0: begin
                pad_scl_o    = m_scl_o_i[0];
                pad_sda_o    = m_sda_o_i[0];
                pad_scl_oe_o = m_scl_oe_i[0];
                pad_sda_oe_o = m_sda_oe_i[0];
                m_scl_i_o[0] = scl_s;
                m_sda_i_o[0] = sda_s;
            end
            StOwn1: begin
                pad_scl_o    = m_scl_o_i[1];
                pad_sda_o    = m_sda_o_i[1];
                pad_scl_oe_o = m_scl_oe_i[1];
                pad_sda_oe_o = m_sda_oe_i[1];
                m_scl_i_o[1] = scl_s;
                m_sda_i_o[1] = sda_s;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_bus_arb.sv
// Bench for i2c_bus_arb: directed scenarios plus randomized arbitration rounds
// checked against a rule-level model of the round-robin tie break.
module tb_i2c_bus_arb;

    localparam int unsigned IDLE = 8;
    localparam int unsigned WDOG = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] m_scl_o, m_sda_o, m_scl_oe, m_sda_oe;
    logic [1:0] m_scl_i, m_sda_i;
    logic       ext_scl, ext_sda;
    logic       pad_scl_i, pad_sda_i;
    logic       pad_scl_o, pad_sda_o, pad_scl_oe, pad_sda_oe;
    logic       busy, wdog;

    int tests = 0;
    int fails = 0;
    int model_last;

    // Wired-AND bus: external device and the pad driver can both pull low
    assign pad_scl_i = ext_scl & (pad_scl_oe ? pad_scl_o : 1'b1);
    assign pad_sda_i = ext_sda & (pad_sda_oe ? pad_sda_o : 1'b1);

    always #5 clk = ~clk;

    i2c_bus_arb #(.IDLE_CYC(IDLE), .WDOG_CYC(WDOG)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .gnt_o       (gnt),
        .m_scl_o_i   (m_scl_o),
        .m_sda_o_i   (m_sda_o),
        .m_scl_oe_i  (m_scl_oe),
        .m_sda_oe_i  (m_sda_oe),
        .m_scl_i_o   (m_scl_i),
        .m_sda_i_o   (m_sda_i),
        .pad_scl_i   (pad_scl_i),
        .pad_sda_i   (pad_sda_i),
        .pad_scl_o   (pad_scl_o),
        .pad_sda_o   (pad_sda_o),
        .pad_scl_oe_o(pad_scl_oe),
        .pad_sda_oe_o(pad_sda_oe),
        .bus_busy_o  (busy),
        .wdog_o      (wdog)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic release_m();
        m_scl_o  = 2'b11;
        m_sda_o  = 2'b11;
        m_scl_oe = 2'b00;
        m_sda_oe = 2'b00;
    endtask

    task automatic drive(input int k, input logic scl, input logic sda);
        m_scl_o[k]  = scl;
        m_sda_o[k]  = sda;
        m_scl_oe[k] = 1'b1;
        m_sda_oe[k] = 1'b1;
    endtask

    // Owner k runs START, nbits random data bits, STOP; non-owner drives junk
    task automatic frame(input int k, input int nbits);
        logic b;
        int   o;
        o = 1 - k;
        drive(k, 1'b1, 1'b1); hold(4);
        drive(k, 1'b1, 1'b0); hold(4);
        chk("busy_after_start", busy, 1);
        drive(k, 1'b0, 1'b0); hold(4);
        for (int i = 0; i < nbits; i++) begin
            b = 1'($urandom);
            drive(k, 1'b0, b);
            m_scl_o[o]  = 1'($urandom);
            m_sda_o[o]  = 1'($urandom);
            m_scl_oe[o] = 1'($urandom);
            m_sda_oe[o] = 1'($urandom);
            #1;
            chk("pad_sda_o_owner", pad_sda_o, b);
            chk("pad_sda_oe_owner", pad_sda_oe, 1);
            hold(4);
            drive(k, 1'b1, b); hold(4);
            chk("m_sda_in_owner", m_sda_i[k], b);
            chk("m_scl_in_owner", m_scl_i[k], 1);
            chk("m_sda_in_other", m_sda_i[o], 1);
            chk("m_scl_in_other", m_scl_i[o], 1);
            drive(k, 1'b0, b); hold(4);
        end
        drive(k, 1'b0, 1'b0); hold(4);
        drive(k, 1'b1, 1'b0); hold(4);
        drive(k, 1'b1, 1'b1); hold(4);
        chk("busy_after_stop", busy, 0);
        release_m();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int pat, win, n, pulses, pulse_at, drop_at;

        rst = 1'b1; req = 2'b00; ext_scl = 1'b1; ext_sda = 1'b1;
        release_m();
        hold(3);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wdog", wdog, 0);
        chk("rst_scl_oe", pad_scl_oe, 0);
        chk("rst_sda_oe", pad_sda_oe, 0);
        chk("rst_scl_o", pad_scl_o, 1);
        chk("rst_sda_o", pad_sda_o, 1);
        chk("rst_m_scl_i", m_scl_i, 2'b11);
        chk("rst_m_sda_i", m_sda_i, 2'b11);
        rst = 1'b0;
        hold(2);

        // Single request: one-cycle grant latency, pads follow requester 0
        req = 2'b01;
        #1 chk("gnt_before_edge", gnt, 0);
        tick();
        chk("gnt_single", gnt, 2'b01);
        chk("m_scl_i_other_single", m_scl_i[1], 1);
        chk("m_sda_i_owner_single", m_sda_i[0], 1);
        for (int i = 0; i < 8; i++) begin
            m_scl_o  = 2'($urandom);
            m_sda_o  = 2'($urandom);
            m_scl_oe = 2'($urandom);
            m_sda_oe = 2'($urandom);
            #1;
            chk("mux_scl_o", pad_scl_o, m_scl_o[0]);
            chk("mux_sda_o", pad_sda_o, m_sda_o[0]);
            chk("mux_scl_oe", pad_scl_oe, m_scl_oe[0]);
            chk("mux_sda_oe", pad_sda_oe, m_sda_oe[0]);
            release_m();
            tick();
        end
        frame(0, 3);
        req = 2'b00;
        tick();
        chk("release_gnt", gnt, 0);
        chk("release_sda_oe", pad_sda_oe, 0);
        hold(2);

        // Tie from reset goes to requester 0, then alternates
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req = 2'b11;
        tick();
        chk("tie_first", gnt, 2'b01);
        frame(0, 2);
        req = 2'b10;
        tick();
        chk("tie_drain_gnt", gnt, 0);
        n = 0;
        while (gnt === 2'b00 && n < 5) begin
            tick();
            n++;
        end
        chk("tie_handover", gnt, 2'b10);
        frame(1, 2);
        req = 2'b00; tick(); hold(2);
        req = 2'b11;
        tick();
        chk("tie_repeat", gnt, 2'b01);
        req = 2'b00; tick(); hold(2);
        model_last = 0;

        // Random rounds: winner predicted from the tie-break rule alone
        for (int t = 0; t < 12; t++) begin
            pat = int'($urandom_range(1, 3));
            if (pat == 3) win = 1 - model_last;
            else          win = (pat == 2) ? 1 : 0;
            model_last = win;
            req = 2'(pat);
            tick();
            chk("rand_grant", gnt, (win == 1) ? 2'b10 : 2'b01);
            frame(win, int'($urandom_range(1, 6)));
            req = 2'b00;
            tick();
            chk("rand_release", gnt, 0);
            hold(2);
        end

        // Busy hold-off: external START blocks a request until STOP
        ext_sda = 1'b0;
        hold(2);
        req = 2'b10;
        hold(10);
        chk("holdoff_gnt", gnt, 0);
        chk("holdoff_busy", busy, 1);
        ext_sda = 1'b1;
        hold(3);
        chk("holdoff_busy_clear", busy, 0);
        chk("holdoff_gnt_pending", gnt, 0);
        tick();
        chk("holdoff_grant", gnt, 2'b10);

        // Drain: owner leaves the bus busy; only the idle timeout frees it
        drive(1, 1'b1, 1'b0); hold(4);
        chk("drain_busy", busy, 1);
        drive(1, 1'b0, 1'b0); hold(4);
        ext_scl = 1'b0;
        req = 2'b00;
        tick();
        chk("drain_gnt", gnt, 0);
        chk("drain_sda_oe", pad_sda_oe, 0);
        chk("drain_scl_oe", pad_scl_oe, 0);
        release_m();
        hold(4);
        ext_scl = 1'b1;
        req = 2'b01;
        n = 0;
        while (gnt === 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_wait_window", (n >= int'(IDLE)) && (n <= int'(IDLE) + 6), 1);
        chk("drain_then_grant", gnt, 2'b01);

        // Reset mid-frame releases the pads on the first reset edge
        req = 2'b00; tick(); hold(2);
        req = 2'b10;
        tick();
        chk("mid_grant", gnt, 2'b10);
        drive(1, 1'b1, 1'b0);
        #1 chk("mid_sda_oe", pad_sda_oe, 1);
        hold(2);
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_sda_oe", pad_sda_oe, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0; req = 2'b00;
        release_m();
        hold(IDLE + 4);

        // Long ownership: watchdog revokes at cycle WDOG, or never without it
        req = 2'b01;
        tick();
        chk("long_grant", gnt, 2'b01);
        pulses = 0; pulse_at = 0; drop_at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (wdog === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
            if (gnt === 2'b00 && drop_at == 0) drop_at = i;
        end
`ifdef I2C_ARB_WDOG_EN
        chk("wdog_pulses", pulses, 1);
        chk("wdog_pulse_cycle", pulse_at, WDOG);
        chk("wdog_gnt_drop_cycle", drop_at, WDOG);
        chk("wdog_no_regrant", gnt, 0);
        req = 2'b00; tick();
        req = 2'b01; tick(); tick();
        chk("wdog_regrant_after_low", gnt, 2'b01);
`else
        chk("nowdog_pulses", pulses, 0);
        chk("nowdog_drop", drop_at, 0);
        chk("nowdog_gnt", gnt, 2'b01);
`endif
        req = 2'b00;
        tick();
        chk("final_release", gnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
